// File: rtl/uart_pkg.sv
// Shared register map, bit positions and defaults for the UART receive FIFO block.
package uart_pkg;

    localparam int DEPTH_DEFAULT = 16;

    localparam int ADDR_RXDATA = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_CTRL   = 2;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVR_BIT   = 2;
    localparam int ST_COUNT_LSB = 4;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;

    // Count field is 9 bits wide so that DEPTH=256 still fits.
    function automatic logic [31:0] status_word(input logic       empty,
                                                input logic       full,
                                                input logic       ovr,
                                                input logic [8:0] count);
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY_BIT]        = empty;
        w[ST_FULL_BIT]         = full;
        w[ST_OVR_BIT]          = ovr;
        w[ST_COUNT_LSB +: 9]   = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_wb_byte_fifo.sv
// Byte-wide circular FIFO with flush; a pop makes room for a same-cycle push when full.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // Flush wins over both operations; the pushed byte is simply dropped.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo_wb.sv
// UART receive byte FIFO with a Wishbone classic slave: RXDATA pop, STATUS, CTRL flush/clear.
module uart_rx_fifo_wb
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          irq
);

    localparam int PW = $clog2(DEPTH);

    logic        rx_done_q;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        ovr_q, ovr_d;

    logic        req, rd, wr;
    logic        sel_rx, sel_st, sel_ctrl;
    logic        push, pop, flush, clr_ovr, ovr_set;
    logic [7:0]  fifo_dout;
    logic [PW:0] fifo_count;
    logic        fifo_empty, fifo_full;
    logic        unused_dat;

    assign unused_dat = ^wb_dat_i[31:2];

    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign rd       = req & ~wb_we_i;
    assign wr       = req & wb_we_i;
    assign sel_rx   = (wb_adr_i == AW'(ADDR_RXDATA));
    assign sel_st   = (wb_adr_i == AW'(ADDR_STATUS));
    assign sel_ctrl = (wb_adr_i == AW'(ADDR_CTRL));

    assign push     = rx_done & ~rx_done_q;
    assign pop      = rd & sel_rx & ~fifo_empty;
    assign flush    = wr & sel_ctrl & wb_dat_i[CTRL_FLUSH_BIT];
    assign clr_ovr  = wr & sel_ctrl & wb_dat_i[CTRL_CLR_OVR_BIT];

    // A push is lost only if nothing frees a slot this cycle and no flush discards it anyway.
    assign ovr_set  = push & fifo_full & ~pop & ~flush;
    assign ovr_d    = ovr_set | (ovr_q & ~clr_ovr);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        ack_d = req;
        dat_d = '0;
        if (rd) begin
            if (sel_rx && !fifo_empty) dat_d = {24'b0, fifo_dout};
            else if (sel_st)           dat_d = status_word(fifo_empty, fifo_full, ovr_q, 9'(fifo_count));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b1;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            ovr_q     <= ovr_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = ~fifo_empty;

endmodule
